// File: rtl/ex_lsu_stage_pkg.sv
// Shared types for the execute/load-store stage: access sizes, FSM states,
// the in_mem_op field layout and the ld_flag layout handed to ME.
package ex_lsu_stage_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MC    = 2'd1,
    ST_REQ   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [1:0] size;
  } mem_op_t;

  typedef struct packed {
    logic       sign;
    logic [1:0] size;
    logic [1:0] off;
  } ld_flag_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == MEM_SIZE_H) && off[0]) || ((size == MEM_SIZE_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ex_lsu_stage_st_align.sv
// Store formatting: replicates store data across byte lanes, builds the byte
// strobes from size/offset and flags misaligned half/word accesses.
module ex_lsu_stage_st_align
  import ex_lsu_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] rkd,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic              ale
);

  always_comb begin
    wstrb = 4'b1111;
    wdata = rkd;
    case (size)
      MEM_SIZE_B: begin
        wstrb = 4'b0001 << off;
        wdata = {4{rkd[7:0]}};
      end
      MEM_SIZE_H: begin
        wstrb = 4'b0011 << off;
        wdata = {2{rkd[15:0]}};
      end
      default: ;
    endcase
  end

  assign ale = misaligned(size, off);

endmodule

// File: rtl/ex_lsu_stage.sv
// Execute stage: holds one instruction, drives the ALU/multi-cycle unit and
// issues loads/stores with a req/addr_ok handshake before offering it to ME.
module ex_lsu_stage
  import ex_lsu_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEST_W      = 5,
  parameter int MC_EN       = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [DATA_W-1:0] in_rkd,
  input  logic [3:0]        in_mem_op,
  input  logic              in_sign,
  input  logic              in_is_mc,
  input  logic              in_gr_we,
  input  logic [DEST_W-1:0] in_dest,
  output logic [DATA_W-1:0] fu_src1,
  output logic [DATA_W-1:0] fu_src2,
  input  logic [DATA_W-1:0] fu_result,
  output logic              mc_start,
  output logic              mc_cancel,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_result,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_gr_we,
  output logic              out_is_load,
  output logic [4:0]        out_ld_flag,
  output logic              out_ale,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_result,
  output logic              fwd_res_ok,
  output logic              fwd_is_load
);

  state_e            state_q, state_d;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] src1_q, src2_q, rkd_q, mc_res_q;
  mem_op_t           mop_q;
  logic              sign_q, is_mc_q, gr_we_q, mc_first_q;
  logic [DEST_W-1:0] dest_q;

  mem_op_t           in_mop;
  logic [1:0]        in_off;
  logic              accept, is_mc_in, ale_in, is_mem_q, st_ale;
  logic [31:0]       addr;
  logic [3:0]        st_wstrb;
  ld_flag_t          ld_flag;

  assign in_mop   = mem_op_t'(in_mem_op);
  assign in_off   = in_src1[1:0] + in_src2[1:0];
  assign is_mc_in = (MC_EN != 0) && in_is_mc;
  assign ale_in   = (ALIGN_CHECK != 0) && (in_mop.is_load || in_mop.is_store)
                    && misaligned(in_mop.size, in_off);

  assign in_ready = !flush && ((state_q == ST_EMPTY) || ((state_q == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // Flush wins over everything; accept is only possible from EMPTY or a draining HOLD.
  always_comb begin
    state_d   = state_q;
    mc_cancel = 1'b0;
    if (flush) begin
      state_d   = ST_EMPTY;
      mc_cancel = (state_q == ST_MC);
    end else if (accept) begin
      if (is_mc_in)
        state_d = ST_MC;
      else if ((in_mop.is_load || in_mop.is_store) && !ale_in)
        state_d = ST_REQ;
      else
        state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_MC:   if (mc_done)     state_d = ST_HOLD;
        ST_REQ:  if (mem_addr_ok) state_d = ST_HOLD;
        ST_HOLD: if (out_ready)   state_d = ST_EMPTY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_EMPTY;
      pc_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      rkd_q      <= '0;
      mc_res_q   <= '0;
      mop_q      <= '0;
      sign_q     <= 1'b0;
      is_mc_q    <= 1'b0;
      gr_we_q    <= 1'b0;
      mc_first_q <= 1'b0;
      dest_q     <= '0;
    end else begin
      state_q    <= state_d;
      mc_first_q <= 1'b0;
      if (accept) begin
        pc_q       <= in_pc;
        src1_q     <= in_src1;
        src2_q     <= in_src2;
        rkd_q      <= in_rkd;
        mop_q      <= in_mop;
        sign_q     <= in_sign;
        is_mc_q    <= is_mc_in;
        gr_we_q    <= in_gr_we;
        dest_q     <= in_dest;
        mc_first_q <= is_mc_in;
      end
      if ((state_q == ST_MC) && mc_done && !flush)
        mc_res_q <= mc_result;
    end
  end

  assign addr     = src1_q + src2_q;
  assign is_mem_q = mop_q.is_load || mop_q.is_store;

  ex_lsu_stage_st_align #(.DATA_W(DATA_W)) u_st_align (
    .size  (mop_q.size),
    .off   (addr[1:0]),
    .rkd   (rkd_q),
    .wstrb (st_wstrb),
    .wdata (mem_wdata),
    .ale   (st_ale)
  );

  assign fu_src1   = src1_q;
  assign fu_src2   = src2_q;
  assign mc_start  = (state_q == ST_MC) && mc_first_q && !flush;
  assign mem_req   = (state_q == ST_REQ) && !flush;
  assign mem_wr    = mop_q.is_store;
  assign mem_size  = mop_q.size;
  assign mem_addr  = addr;
  assign mem_wstrb = mop_q.is_store ? st_wstrb : 4'b0000;

  assign out_valid = (state_q == ST_HOLD);

  always_comb begin
    out_result = '0;
    if (state_q == ST_HOLD) begin
      if (is_mc_q)       out_result = mc_res_q;
      else if (is_mem_q) out_result = addr;
      else               out_result = fu_result;
    end
  end

  assign ld_flag     = '{sign: sign_q, size: mop_q.size, off: addr[1:0]};
  assign out_pc      = pc_q;
  assign out_dest    = dest_q;
  assign out_gr_we   = gr_we_q;
  assign out_is_load = mop_q.is_load;
  assign out_ld_flag = ld_flag;
  assign out_ale     = (state_q == ST_HOLD) && (ALIGN_CHECK != 0) && is_mem_q && st_ale;

  assign fwd_dest    = ((state_q != ST_EMPTY) && gr_we_q) ? dest_q : '0;
  assign fwd_result  = out_result;
  assign fwd_res_ok  = (state_q == ST_HOLD) && !mop_q.is_load;
  assign fwd_is_load = (state_q != ST_EMPTY) && mop_q.is_load;

endmodule

// File: tb/tb_ex_lsu_stage.sv
// Directed bench for ex_lsu_stage: an ALU vector table plus hand-written
// sequences for store/load handshakes, ALE, multi-cycle ops, flush and reset.
module tb_ex_lsu_stage;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid;
  logic [31:0] in_pc, in_src1, in_src2, in_rkd;
  logic [3:0]  in_mem_op;
  logic        in_sign, in_is_mc, in_gr_we;
  logic [4:0]  in_dest;
  logic        mc_done, mem_addr_ok, out_ready;
  logic [31:0] mc_result;

  logic        in_ready, mc_start, mc_cancel, mem_req, mem_wr, out_valid;
  logic        out_gr_we, out_is_load, out_ale, fwd_res_ok, fwd_is_load;
  logic [31:0] fu_src1, fu_src2, fu_result, mem_addr, mem_wdata, out_pc, out_result, fwd_result;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [4:0]  out_dest, out_ld_flag, fwd_dest;

  // Second instance without the alignment check; shares all inputs.
  logic        n_in_ready, n_mc_start, n_mc_cancel, n_mem_req, n_mem_wr, n_out_valid;
  logic        n_out_gr_we, n_out_is_load, n_out_ale, n_fwd_res_ok, n_fwd_is_load;
  logic [31:0] n_fu_src1, n_fu_src2, n_fu_result, n_mem_addr, n_mem_wdata, n_out_pc;
  logic [31:0] n_out_result, n_fwd_result;
  logic [1:0]  n_mem_size;
  logic [3:0]  n_mem_wstrb;
  logic [4:0]  n_out_dest, n_out_ld_flag, n_fwd_dest;

  always #5 clk = ~clk;

  // External single-cycle ALU model: an adder.
  assign fu_result   = fu_src1 + fu_src2;
  assign n_fu_result = n_fu_src1 + n_fu_src2;

  ex_lsu_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_rkd(in_rkd),
    .in_mem_op(in_mem_op), .in_sign(in_sign), .in_is_mc(in_is_mc), .in_gr_we(in_gr_we),
    .in_dest(in_dest), .fu_src1(fu_src1), .fu_src2(fu_src2), .fu_result(fu_result),
    .mc_start(mc_start), .mc_cancel(mc_cancel), .mc_done(mc_done), .mc_result(mc_result),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_result(out_result),
    .out_dest(out_dest), .out_gr_we(out_gr_we), .out_is_load(out_is_load),
    .out_ld_flag(out_ld_flag), .out_ale(out_ale), .fwd_dest(fwd_dest),
    .fwd_result(fwd_result), .fwd_res_ok(fwd_res_ok), .fwd_is_load(fwd_is_load)
  );

  ex_lsu_stage #(.ALIGN_CHECK(0)) n_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_rkd(in_rkd),
    .in_mem_op(in_mem_op), .in_sign(in_sign), .in_is_mc(in_is_mc), .in_gr_we(in_gr_we),
    .in_dest(in_dest), .fu_src1(n_fu_src1), .fu_src2(n_fu_src2), .fu_result(n_fu_result),
    .mc_start(n_mc_start), .mc_cancel(n_mc_cancel), .mc_done(mc_done), .mc_result(mc_result),
    .mem_req(n_mem_req), .mem_wr(n_mem_wr), .mem_size(n_mem_size), .mem_wstrb(n_mem_wstrb),
    .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_addr_ok(mem_addr_ok),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
    .out_result(n_out_result), .out_dest(n_out_dest), .out_gr_we(n_out_gr_we),
    .out_is_load(n_out_is_load), .out_ld_flag(n_out_ld_flag), .out_ale(n_out_ale),
    .fwd_dest(n_fwd_dest), .fwd_result(n_fwd_result), .fwd_res_ok(n_fwd_res_ok),
    .fwd_is_load(n_fwd_is_load)
  );

  typedef struct {
    logic        v;
    logic [31:0] s1, s2;
    logic [4:0]  dest;
    logic        exp_valid;
    logic [31:0] exp_res;
    logic [4:0]  exp_fwd_dest;
    logic        exp_ready;
  } alu_vec_t;

  alu_vec_t vecs [6];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_pc = 0; in_src1 = 0; in_src2 = 0; in_rkd = 0;
    in_mem_op = 0; in_sign = 0; in_is_mc = 0; in_gr_we = 0; in_dest = 0;
    mc_done = 0; mc_result = 0; mem_addr_ok = 1; out_ready = 1;
  endtask

  initial begin
    // Each row's expectations describe the instruction accepted on the previous row.
    vecs[0] = '{1'b1, 32'd1, 32'd2, 5'd1, 1'b0, 32'd0, 5'd0, 1'b1};
    vecs[1] = '{1'b1, 32'd3, 32'd4, 5'd2, 1'b1, 32'd3, 5'd1, 1'b1};
    vecs[2] = '{1'b1, 32'd5, 32'd6, 5'd3, 1'b1, 32'd7, 5'd2, 1'b1};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 32'd11, 5'd3, 1'b1};
    vecs[4] = '{1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 32'd0, 5'd4, 1'b1};
    vecs[5] = '{1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1};

    idle_inputs();
    resetn = 0;
    repeat (2) next_cycle();
    resetn = 1;
    settle();
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset mc_start", {31'd0, mc_start}, 32'd0);
    chk("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset fwd_dest", {27'd0, fwd_dest}, 32'd0);
    $display("txn reset done");

    // ALU stream, one instruction per cycle.
    for (int i = 0; i < 6; i++) begin
      in_valid = vecs[i].v; in_src1 = vecs[i].s1; in_src2 = vecs[i].s2;
      in_dest = vecs[i].dest; in_gr_we = 1'b1;
      settle();
      chk($sformatf("alu%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ready});
      chk($sformatf("alu%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("alu%0d out_result", i), out_result, vecs[i].exp_res);
      chk($sformatf("alu%0d fwd_dest", i), {27'd0, fwd_dest}, {27'd0, vecs[i].exp_fwd_dest});
      chk($sformatf("alu%0d fwd_res_ok", i), {31'd0, fwd_res_ok}, {31'd0, vecs[i].exp_valid});
      $display("txn alu row %0d src1=0x%08h src2=0x%08h result=0x%08h", i, vecs[i].s1, vecs[i].s2, out_result);
      next_cycle();
    end
    idle_inputs();

    // Store byte at 0x1003 with addr_ok held low for two cycles.
    in_valid = 1; in_src1 = 32'h1000; in_src2 = 32'd3; in_rkd = 32'hAB;
    in_mem_op = 4'b0100; mem_addr_ok = 0;
    settle();
    chk("sb idle mem_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      mem_addr_ok = (k == 2);
      settle();
      chk($sformatf("sb req%0d mem_req", k), {31'd0, mem_req}, 32'd1);
      chk($sformatf("sb req%0d mem_addr", k), mem_addr, 32'h1003);
      chk($sformatf("sb req%0d mem_wstrb", k), {28'd0, mem_wstrb}, 32'h8);
      chk($sformatf("sb req%0d mem_wdata", k), mem_wdata, 32'hABAB_ABAB);
      chk($sformatf("sb req%0d mem_wr", k), {31'd0, mem_wr}, 32'd1);
      chk($sformatf("sb req%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      next_cycle();
    end
    settle();
    chk("sb hold out_valid", {31'd0, out_valid}, 32'd1);
    chk("sb hold mem_req", {31'd0, mem_req}, 32'd0);
    chk("sb hold out_result", out_result, 32'h1003);
    $display("txn store byte addr=0x00001003 wstrb=%b", 4'b1000);
    next_cycle();
    idle_inputs();

    // Misaligned load word at 0x1002.
    in_valid = 1; in_src1 = 32'h1000; in_src2 = 32'd2; in_mem_op = 4'b1010;
    in_gr_we = 1; in_dest = 5'd4;
    settle();
    chk("lw ale accept mem_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    in_valid = 0;
    settle();
    chk("lw ale mem_req", {31'd0, mem_req}, 32'd0);
    chk("lw ale out_valid", {31'd0, out_valid}, 32'd1);
    chk("lw ale out_ale", {31'd0, out_ale}, 32'd1);
    chk("lw ale out_is_load", {31'd0, out_is_load}, 32'd1);
    chk("lw ale fwd_res_ok", {31'd0, fwd_res_ok}, 32'd0);
    chk("lw ale fwd_is_load", {31'd0, fwd_is_load}, 32'd1);
    chk("lw ale ld_flag", {27'd0, out_ld_flag}, 32'h0A);
    chk("lw nochk mem_req", {31'd0, n_mem_req}, 32'd1);
    chk("lw nochk mem_addr", n_mem_addr, 32'h1002);
    chk("lw nochk mem_wstrb", {28'd0, n_mem_wstrb}, 32'd0);
    $display("txn load word addr=0x00001002 ale=%0d", out_ale);
    next_cycle();
    settle();
    chk("lw ale drained mem_req", {31'd0, mem_req}, 32'd0);
    chk("lw ale drained out_valid", {31'd0, out_valid}, 32'd0);
    next_cycle();
    idle_inputs();

    // Multi-cycle op finishing on the fifth MC cycle.
    in_valid = 1; in_is_mc = 1; in_src1 = 32'd49; in_src2 = 32'd7; in_gr_we = 1; in_dest = 5'd9;
    settle();
    next_cycle();
    in_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      mc_done = (k == 5);
      mc_result = (k == 5) ? 32'd7 : 32'h99;
      settle();
      chk($sformatf("div mc%0d mc_start", k), {31'd0, mc_start}, (k == 1) ? 32'd1 : 32'd0);
      chk($sformatf("div mc%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("div mc%0d out_valid", k), {31'd0, out_valid}, 32'd0);
      chk($sformatf("div mc%0d fwd_res_ok", k), {31'd0, fwd_res_ok}, 32'd0);
      next_cycle();
    end
    mc_done = 0; mc_result = 0;
    settle();
    chk("div hold out_valid", {31'd0, out_valid}, 32'd1);
    chk("div hold out_result", out_result, 32'd7);
    chk("div hold fwd_res_ok", {31'd0, fwd_res_ok}, 32'd1);
    chk("div hold fwd_dest", {27'd0, fwd_dest}, 32'd9);
    $display("txn div result=0x%08h", out_result);
    next_cycle();
    idle_inputs();

    // Flush in the third MC cycle; a same-cycle input and a late mc_done are dropped.
    in_valid = 1; in_is_mc = 1; in_gr_we = 1; in_dest = 5'd3;
    settle();
    next_cycle();
    in_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      flush = (k == 3);
      in_valid = (k == 3);
      settle();
      chk($sformatf("flush mc%0d mc_cancel", k), {31'd0, mc_cancel}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk("flush in_ready", {31'd0, in_ready}, 32'd0);
      next_cycle();
    end
    flush = 0; in_valid = 0; mc_done = 1; mc_result = 32'h55;
    settle();
    chk("flush after out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush after mc_cancel", {31'd0, mc_cancel}, 32'd0);
    chk("flush after in_ready", {31'd0, in_ready}, 32'd1);
    next_cycle();
    mc_done = 0;
    settle();
    chk("flush late done out_valid", {31'd0, out_valid}, 32'd0);
    $display("txn flush during mc");
    idle_inputs();

    // HOLD stalled by out_ready=0 for four cycles.
    in_valid = 1; in_pc = 32'h1C00_0040; in_src1 = 32'h10; in_src2 = 32'h20;
    in_gr_we = 1; in_dest = 5'd7; out_ready = 0;
    settle();
    next_cycle();
    in_pc = 32'h1C00_0044; in_src1 = 32'h99; in_src2 = 32'h1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d out_result", k), out_result, 32'h30);
      chk($sformatf("stall%0d out_dest", k), {27'd0, out_dest}, 32'd7);
      chk($sformatf("stall%0d out_pc", k), out_pc, 32'h1C00_0040);
      chk($sformatf("stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      next_cycle();
    end
    in_valid = 0; out_ready = 1;
    settle();
    chk("stall release out_result", out_result, 32'h30);
    $display("txn hold stall result=0x%08h", out_result);
    next_cycle();
    idle_inputs();

    // Flush in REQ masks mem_req in the same cycle.
    in_valid = 1; in_src1 = 32'h3000; in_mem_op = 4'b0110; mem_addr_ok = 0;
    settle();
    next_cycle();
    in_valid = 0; flush = 1;
    settle();
    chk("flush req mem_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    flush = 0;
    settle();
    chk("flush req empty in_ready", {31'd0, in_ready}, 32'd1);
    $display("txn flush during req");
    idle_inputs();

    // Reset asserted mid-REQ.
    in_valid = 1; in_src1 = 32'h2000; in_rkd = 32'h1234_5678; in_mem_op = 4'b0110; mem_addr_ok = 0;
    settle();
    next_cycle();
    in_valid = 0; mem_addr_ok = 0;
    settle();
    chk("rst req mem_req", {31'd0, mem_req}, 32'd1);
    chk("rst req mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
    resetn = 0;
    next_cycle();
    settle();
    chk("rst after mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst after in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst after out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst after mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst after mem_addr", mem_addr, 32'd0);
    $display("txn reset during req");
    resetn = 1;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
